interrupt_sequencer: RTL

- Sequences the CPU datapath through reset, NMI and IRQ entry.
- On reset release, fetches the reset vector into PC.
- At an instruction boundary with a pending interrupt:
  - pushes PCH, PCL and P to the stack page;
  - sets I;
  - loads PC from the selected vector.
- Sits beside control_unit and owns the memory bus while busy; control_unit gates instruction_load/increment_pc with int_take.

---
 rtl/interrupt_sequencer_if.sv | 40 ++++
 rtl/interrupt_sequencer.sv | 114 +++++++++++
 2 files changed

// File: rtl/interrupt_sequencer_if.sv
// interrupt_sequencer_if: CPU-side and memory-bus signals of the interrupt sequencer.
// brk_req exists only when INTERRUPT_SEQUENCER_BRK_EN is defined.
interface interrupt_sequencer_if;
    logic        nmi_n;
    logic        irq_n;
    logic        i_flag;
    logic        fetch;
    logic [15:0] pc;
    logic [7:0]  status;
    logic [7:0]  sp;
    logic [7:0]  data_in;
`ifdef INTERRUPT_SEQUENCER_BRK_EN
    logic        brk_req;
`endif
    logic        int_take;
    logic        busy;
    logic [15:0] address;
    logic [7:0]  data_out;
    logic        read_write;
    logic        sp_dec;
    logic        pc_load;
    logic [15:0] pc_new;
    logic        set_i;

    modport master (
`ifdef INTERRUPT_SEQUENCER_BRK_EN
        input  brk_req,
`endif
        input  nmi_n, irq_n, i_flag, fetch, pc, status, sp, data_in,
        output int_take, busy, address, data_out, read_write, sp_dec, pc_load, pc_new, set_i
    );

    modport slave (
`ifdef INTERRUPT_SEQUENCER_BRK_EN
        output brk_req,
`endif
        output nmi_n, irq_n, i_flag, fetch, pc, status, sp, data_in,
        input  int_take, busy, address, data_out, read_write, sp_dec, pc_load, pc_new, set_i
    );
endinterface

// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: drives reset-vector fetch and NMI/IRQ entry (push PC/P, set I, load vector).
// Defining INTERRUPT_SEQUENCER_BRK_EN adds BRK entry through IRQ_VECTOR with B=1 pushed.
module interrupt_sequencer #(
    parameter logic [15:0] NMI_VECTOR   = 16'hFFFA,
    parameter logic [15:0] RESET_VECTOR = 16'hFFFC,
    parameter logic [15:0] IRQ_VECTOR   = 16'hFFFE
) (
    input logic                   clk,
    input logic                   rst,
    interrupt_sequencer_if.master bus
);
    typedef enum logic [2:0] {RST_LO, RST_HI, IDLE, PUSH_PCH, PUSH_PCL, PUSH_P, VEC_LO, VEC_HI} state_t;

    state_t      state_q, state_d;
    logic        nmi_pending_q, nmi_pending_d;
    logic        nmi_prev_q;
    logic        brk_q, brk_d;
    logic [15:0] vec_sel_q, vec_sel_d;
    logic [7:0]  vec_lo_q, vec_lo_d;
    logic        take, brk_in;
    logic [15:0] stack_addr;

`ifdef INTERRUPT_SEQUENCER_BRK_EN
    assign brk_in = bus.brk_req;
`else
    assign brk_in = 1'b0;
`endif

    assign stack_addr = {8'h01, bus.sp};
    assign take = (state_q == IDLE) && bus.fetch &&
                  (nmi_pending_q || (!bus.irq_n && !bus.i_flag) || brk_in);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= RST_LO;
            nmi_pending_q <= 1'b0;
            nmi_prev_q    <= 1'b1;
            brk_q         <= 1'b0;
            vec_sel_q     <= RESET_VECTOR;
            vec_lo_q      <= 8'h00;
        end else begin
            state_q       <= state_d;
            nmi_pending_q <= nmi_pending_d;
            nmi_prev_q    <= bus.nmi_n;
            brk_q         <= brk_d;
            vec_sel_q     <= vec_sel_d;
            vec_lo_q      <= vec_lo_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        // a take with NMI pending always services the NMI, so take alone clears it; a fresh edge still wins
        nmi_pending_d  = (nmi_prev_q && !bus.nmi_n) || (nmi_pending_q && !take);
        vec_sel_d      = take ? (nmi_pending_q ? NMI_VECTOR : IRQ_VECTOR) : vec_sel_q;
        brk_d          = take ? (!nmi_pending_q && brk_in) : brk_q;
        vec_lo_d       = vec_lo_q;
        bus.int_take   = 1'b0;
        bus.busy       = 1'b0;
        bus.address    = 16'h0000;
        bus.data_out   = 8'h00;
        bus.read_write = 1'b0;
        bus.sp_dec     = 1'b0;
        bus.pc_load    = 1'b0;
        bus.pc_new     = 16'h0000;
        bus.set_i      = 1'b0;
        case (state_q)
            RST_LO: begin
                bus.busy    = 1'b1;
                bus.address = RESET_VECTOR;
                vec_lo_d    = bus.data_in;
                state_d     = RST_HI;
            end
            RST_HI: begin
                bus.busy    = 1'b1;
                bus.address = RESET_VECTOR + 16'd1;
                bus.pc_new  = {bus.data_in, vec_lo_q};
                bus.pc_load = 1'b1;
                bus.set_i   = 1'b1;
                state_d     = IDLE;
            end
            IDLE: begin
                bus.int_take = take;
                state_d      = take ? PUSH_PCH : IDLE;
            end
            PUSH_PCH, PUSH_PCL, PUSH_P: begin
                bus.busy       = 1'b1;
                bus.address    = stack_addr;
                bus.read_write = 1'b1;
                bus.sp_dec     = 1'b1;
                bus.data_out   = (state_q == PUSH_PCH) ? bus.pc[15:8] :
                                 (state_q == PUSH_PCL) ? bus.pc[7:0] :
                                 {bus.status[7:6], 1'b1, brk_q, bus.status[3:0]};
                bus.set_i      = (state_q == PUSH_P);
                state_d        = (state_q == PUSH_PCH) ? PUSH_PCL :
                                 (state_q == PUSH_PCL) ? PUSH_P : VEC_LO;
            end
            VEC_LO: begin
                bus.busy    = 1'b1;
                bus.address = vec_sel_q;
                vec_lo_d    = bus.data_in;
                state_d     = VEC_HI;
            end
            VEC_HI: begin
                bus.busy    = 1'b1;
                bus.address = vec_sel_q + 16'd1;
                bus.pc_new  = {bus.data_in, vec_lo_q};
                bus.pc_load = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = RST_LO;
        endcase
    end
endmodule
